// File: rtl/fmap_reader_pkg.sv
// Shared types and lane helpers for the feature-map read engine.
// Lane numbering matches writeback packing so unpacking cannot diverge from it.
package fmap_reader_pkg;

  localparam logic [2:0] BYTE_EIG = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [63:0] data_1;
    logic [63:0] data_2;
    logic        row_end;
    logic        frame_end;
  } fmap_entry_t;

  // idx 0 selects ByteEig (bits 63:56), idx 7 selects ByteOne (bits 7:0).
  function automatic logic [7:0] lane_byte(input logic [63:0] word, input logic [2:0] idx);
    logic [2:0] lane;
    lane = BYTE_EIG - idx;
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fmap_word_fifo.sv
// Two-entry shift-style word buffer; the head always sits in a fixed register.
module fmap_word_fifo
  import fmap_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fmap_entry_t push_data,
  input  logic        pop,
  output fmap_entry_t head,
  output logic [1:0]  count
);

  fmap_entry_t slot_1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      slot_1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else slot_1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= slot_1;
          count <= count - 2'd1;
        end
        // Simultaneous capture and pop keeps occupancy unchanged.
        2'b11: begin
          if (count == 2'd2) begin
            head   <= slot_1;
            slot_1 <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fmap_reader.sv
// Feature-map read engine: walks one band over both BRAM32k ports and
// unpacks each 64-bit word into a byte-serial signed pixel stream.
module fmap_reader
  import fmap_reader_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int ROW_STRIDE    = 128,
  parameter int WORDS_PER_ROW = 4,
  parameter int RD_LAT        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr_1,
  input  logic [ADDR_W-1:0] base_addr_2,
  input  logic [5:0]        num_rows,
  output logic              rd_en_BRAM32k,
  output logic [ADDR_W-1:0] addr_BRAM32k_1,
  output logic [ADDR_W-1:0] addr_BRAM32k_2,
  input  logic [63:0]       dout_BRAM32k_1,
  input  logic [63:0]       dout_BRAM32k_2,
  output logic [7:0]        pix_a,
  output logic [7:0]        pix_b,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              row_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done
);

  localparam int WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [WORD_W-1:0] WORD_MAX = WORD_W'(WORDS_PER_ROW - 1);
  localparam logic ONE_WORD = (WORDS_PER_ROW == 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] base_1, base_2;
  logic [5:0]        rows, row, next_row;
  logic [WORD_W-1:0] word, next_word;
  logic [1:0]        rd_tag;
  logic [RD_LAT:1]   lat_valid;
  logic [1:0]        lat_tag [1:RD_LAT];
  logic [2:0]        idx;
  logic [2:0]        in_flight;
  logic              handshake, pop, push, can_issue, next_last;
  fmap_entry_t       head, push_data;
  logic [1:0]        count;

  function automatic logic [ADDR_W-1:0] addr_calc(input logic [ADDR_W-1:0] base,
                                                  input logic [5:0] r,
                                                  input logic [WORD_W-1:0] w);
    return base + ADDR_W'(r) * ADDR_W'(ROW_STRIDE) + ADDR_W'(w);
  endfunction

  always_comb begin
    in_flight = {2'b00, rd_en_BRAM32k};
    for (int i = 1; i <= RD_LAT; i++) in_flight = in_flight + {2'b00, lat_valid[i]};
    // Credits cover both buffered words and reads still in the BRAM pipeline.
    can_issue = (state == ST_RUN) && (({1'b0, count} + in_flight) < 3'd2);
    if (word == WORD_MAX) begin
      next_word = '0;
      next_row  = row + 6'd1;
    end else begin
      next_word = word + WORD_W'(1);
      next_row  = row;
    end
    next_last = (next_row == rows - 6'd1) && (next_word == WORD_MAX);
  end

  assign pix_valid  = (count != 2'd0);
  assign pix_a      = lane_byte(head.data_1, idx);
  assign pix_b      = lane_byte(head.data_2, idx);
  assign row_last   = pix_valid && (idx == 3'd7) && head.row_end;
  assign frame_last = row_last && head.frame_end;

  assign handshake = pix_valid && pix_ready;
  assign pop       = handshake && (idx == 3'd7);
  assign push      = lat_valid[RD_LAT];
  assign push_data = '{data_1: dout_BRAM32k_1, data_2: dout_BRAM32k_2,
                       row_end: lat_tag[RD_LAT][1], frame_end: lat_tag[RD_LAT][0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      base_1         <= '0;
      base_2         <= '0;
      rows           <= '0;
      row            <= '0;
      word           <= '0;
      rd_en_BRAM32k  <= 1'b0;
      addr_BRAM32k_1 <= '0;
      addr_BRAM32k_2 <= '0;
      rd_tag         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      idx            <= 3'd0;
    end else begin
      rd_en_BRAM32k <= 1'b0;
      done          <= 1'b0;
      if (handshake) idx <= idx + 3'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_rows == 6'd0) begin
              done <= 1'b1;
            end else begin
              base_1         <= base_addr_1;
              base_2         <= base_addr_2;
              rows           <= num_rows;
              row            <= '0;
              word           <= '0;
              rd_en_BRAM32k  <= 1'b1;
              addr_BRAM32k_1 <= base_addr_1;
              addr_BRAM32k_2 <= base_addr_2;
              rd_tag         <= {ONE_WORD, ONE_WORD && (num_rows == 6'd1)};
              busy           <= 1'b1;
              state          <= (ONE_WORD && (num_rows == 6'd1)) ? ST_DRAIN : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (can_issue) begin
            rd_en_BRAM32k  <= 1'b1;
            row            <= next_row;
            word           <= next_word;
            addr_BRAM32k_1 <= addr_calc(base_1, next_row, next_word);
            addr_BRAM32k_2 <= addr_calc(base_2, next_row, next_word);
            rd_tag         <= {next_word == WORD_MAX, next_last};
            if (next_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (handshake && frame_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Row/frame tags ride alongside each read so they reach the buffer with its data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_valid <= '0;
      for (int i = 1; i <= RD_LAT; i++) lat_tag[i] <= '0;
    end else begin
      lat_valid[1] <= rd_en_BRAM32k;
      lat_tag[1]   <= rd_tag;
      for (int i = 2; i <= RD_LAT; i++) begin
        lat_valid[i] <= lat_valid[i-1];
        lat_tag[i]   <= lat_tag[i-1];
      end
    end
  end

  fmap_word_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fmap_reader.sv
// Directed self-checking bench for fmap_reader with a one-cycle-latency BRAM model.
module tb_fmap_reader;

  logic        clk, rst, start, rd_en, pix_valid, pix_ready, row_last, frame_last, busy, done;
  logic [11:0] base_addr_1, base_addr_2, addr1, addr2;
  logic [5:0]  num_rows;
  logic [63:0] dout1, dout2;
  logic [7:0]  pix_a, pix_b;

  logic [63:0] mem1 [4096];
  logic [63:0] mem2 [4096];

  int checks = 0;
  int passes = 0;

  logic [7:0]  beats_a[$];
  logic [7:0]  beats_b[$];
  logic        rl_q[$];
  logic        fl_q[$];
  logic [11:0] addr1_q[$];
  logic [11:0] addr2_q[$];
  int timed_out, first_valid_cyc, first_rd_cyc, done_cyc, last_hs_cyc;
  int stall_viol, max_out, done_pulses, busy_c1, busy_at_done;

  fmap_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr_1    (base_addr_1),
    .base_addr_2    (base_addr_2),
    .num_rows       (num_rows),
    .rd_en_BRAM32k  (rd_en),
    .addr_BRAM32k_1 (addr1),
    .addr_BRAM32k_2 (addr2),
    .dout_BRAM32k_1 (dout1),
    .dout_BRAM32k_2 (dout2),
    .pix_a          (pix_a),
    .pix_b          (pix_b),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .row_last       (row_last),
    .frame_last     (frame_last),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      dout1 <= mem1[addr1];
      dout2 <= mem2[addr2];
    end
  end

  function automatic logic [63:0] pat(input int a, input int seed);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = 8'(a * 7 + k * 29 + seed);
    return w;
  endfunction

  // Beat n: row n/32, word (n/8)%4, byte lane 7-(n%8), 128-word row stride, 12-bit wrap.
  function automatic logic [7:0] exp_a(input logic [11:0] base, input int n);
    logic [11:0] a;
    logic [63:0] w;
    a = base + 12'((n / 32) * 128 + (n / 8) % 4);
    w = mem1[a];
    return w[(7 - n % 8) * 8 +: 8];
  endfunction

  function automatic logic [7:0] exp_b(input logic [11:0] base, input int n);
    logic [11:0] a;
    logic [63:0] w;
    a = base + 12'((n / 32) * 128 + (n / 8) % 4);
    w = mem2[a];
    return w[(7 - n % 8) * 8 +: 8];
  endfunction

  task automatic run_band(input logic [11:0] b1, input logic [11:0] b2, input logic [5:0] rows,
                          input int ready_pct, input int restart_cyc, input int abort_beats);
    int cyc, issued, hs, outst;
    logic stalled;
    logic [17:0] held;
    beats_a.delete(); beats_b.delete(); rl_q.delete(); fl_q.delete();
    addr1_q.delete(); addr2_q.delete();
    timed_out = 0; first_valid_cyc = -1; first_rd_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
    stall_viol = 0; max_out = 0; done_pulses = 0; busy_c1 = 0; busy_at_done = 1;
    issued = 0; hs = 0; stalled = 1'b0; held = '0;
    @(negedge clk);
    base_addr_1 = b1; base_addr_2 = b2; num_rows = rows; start = 1'b1; pix_ready = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = (restart_cyc != 0) && (cyc == restart_cyc);
      if (start) begin
        base_addr_1 = 12'h300; base_addr_2 = 12'h700; num_rows = 6'd5;
      end
      pix_ready = (int'($urandom_range(99)) < ready_pct);
      if (cyc == 1) busy_c1 = busy;
      if (stalled && ({pix_valid, pix_a, pix_b, row_last, frame_last} !== {1'b1, held})) stall_viol++;
      if (rd_en) begin
        issued++;
        addr1_q.push_back(addr1);
        addr2_q.push_back(addr2);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      outst = issued - hs / 8;
      if (outst > max_out) max_out = outst;
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      if (pix_valid && pix_ready) begin
        beats_a.push_back(pix_a); beats_b.push_back(pix_b);
        rl_q.push_back(row_last); fl_q.push_back(frame_last);
        hs++;
        last_hs_cyc = cyc;
      end
      stalled = pix_valid && !pix_ready;
      held = {pix_a, pix_b, row_last, frame_last};
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (abort_beats != 0 && hs == abort_beats) break;
      if (cyc >= 3000) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, addr1, addr2, pix_a, pix_b, pix_valid, row_last, frame_last, busy, done} !== '0)
      $display("[TB] FAIL reset_values got %h want 0",
               {rd_en, addr1, addr2, pix_a, pix_b, pix_valid, row_last, frame_last, busy, done});
    else passes++;
    rst = 1'b1;
  endtask

  task automatic test_basic_read();
    mem1[0] = 64'h0102030405060708;
    run_band(12'd0, 12'd128, 6'd1, 100, 0, 0);
    checks++; if (timed_out !== 0) $display("[TB] FAIL basic_timeout got %0d want 0", timed_out); else passes++;
    checks++; if (beats_a.size() !== 32) $display("[TB] FAIL basic_beats got %0d want 32", beats_a.size()); else passes++;
    for (int n = 0; n < 8 && n < beats_a.size(); n++) begin
      checks++;
      if (beats_a[n] !== 8'(n + 1)) $display("[TB] FAIL basic_pix_a[%0d] got %h want %h", n, beats_a[n], 8'(n + 1));
      else passes++;
    end
    for (int n = 0; n < beats_a.size(); n++) begin
      checks++;
      if ({beats_a[n], beats_b[n], rl_q[n], fl_q[n]} !== {exp_a(12'd0, n), exp_b(12'd128, n), n == 31, n == 31})
        $display("[TB] FAIL basic_beat[%0d] got %h want %h", n, {beats_a[n], beats_b[n], rl_q[n], fl_q[n]},
                 {exp_a(12'd0, n), exp_b(12'd128, n), n == 31, n == 31});
      else passes++;
    end
    checks++; if (first_rd_cyc !== 1) $display("[TB] FAIL basic_first_rd got %0d want 1", first_rd_cyc); else passes++;
    checks++; if (first_valid_cyc !== 3) $display("[TB] FAIL basic_first_valid got %0d want 3", first_valid_cyc); else passes++;
    checks++; if (last_hs_cyc !== first_valid_cyc + 31) $display("[TB] FAIL basic_no_bubbles got %0d want %0d", last_hs_cyc, first_valid_cyc + 31); else passes++;
    checks++; if (done_cyc !== last_hs_cyc + 1) $display("[TB] FAIL basic_done_cyc got %0d want %0d", done_cyc, last_hs_cyc + 1); else passes++;
    checks++; if (done_pulses !== 1) $display("[TB] FAIL basic_done_pulses got %0d want 1", done_pulses); else passes++;
    checks++; if ({busy_c1[0], busy_at_done[0]} !== 2'b10) $display("[TB] FAIL basic_busy got %b want 10", {busy_c1[0], busy_at_done[0]}); else passes++;
    checks++; if (addr1_q.size() !== 4) $display("[TB] FAIL basic_reads got %0d want 4", addr1_q.size()); else passes++;
  endtask

  task automatic test_row_stride();
    run_band(12'd0, 12'd128, 6'd3, 100, 0, 0);
    checks++; if (addr1_q.size() !== 12) $display("[TB] FAIL stride_reads got %0d want 12", addr1_q.size()); else passes++;
    for (int i = 0; i < addr1_q.size(); i++) begin
      checks++;
      if ({addr1_q[i], addr2_q[i]} !== {12'((i / 4) * 128 + i % 4), 12'((i / 4) * 128 + i % 4 + 128)})
        $display("[TB] FAIL stride_addr[%0d] got %h want %h", i, {addr1_q[i], addr2_q[i]},
                 {12'((i / 4) * 128 + i % 4), 12'((i / 4) * 128 + i % 4 + 128)});
      else passes++;
    end
    checks++; if (beats_a.size() !== 96) $display("[TB] FAIL stride_beats got %0d want 96", beats_a.size()); else passes++;
    for (int n = 0; n < beats_a.size(); n++) begin
      checks++;
      if ({beats_a[n], beats_b[n], rl_q[n], fl_q[n]} !== {exp_a(12'd0, n), exp_b(12'd128, n), n % 32 == 31, n == 95})
        $display("[TB] FAIL stride_beat[%0d] got %h want %h", n, {beats_a[n], beats_b[n], rl_q[n], fl_q[n]},
                 {exp_a(12'd0, n), exp_b(12'd128, n), n % 32 == 31, n == 95});
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    run_band(12'h040, 12'h800, 6'd2, 30, 0, 0);
    checks++; if (timed_out !== 0) $display("[TB] FAIL bp_timeout got %0d want 0", timed_out); else passes++;
    checks++; if (beats_a.size() !== 64) $display("[TB] FAIL bp_beats got %0d want 64", beats_a.size()); else passes++;
    for (int n = 0; n < beats_a.size(); n++) begin
      checks++;
      if ({beats_a[n], beats_b[n], rl_q[n], fl_q[n]} !== {exp_a(12'h040, n), exp_b(12'h800, n), n % 32 == 31, n == 63})
        $display("[TB] FAIL bp_beat[%0d] got %h want %h", n, {beats_a[n], beats_b[n], rl_q[n], fl_q[n]},
                 {exp_a(12'h040, n), exp_b(12'h800, n), n % 32 == 31, n == 63});
      else passes++;
    end
    checks++; if (stall_viol !== 0) $display("[TB] FAIL bp_stall_stable got %0d want 0", stall_viol); else passes++;
    checks++; if (max_out > 2) $display("[TB] FAIL bp_outstanding got %0d want <=2", max_out); else passes++;
  endtask

  task automatic test_signed();
    int v;
    mem1[12'h200] = 64'h807F01FF00807F81;
    mem2[12'h600] = 64'h7F80FE0281008000;
    run_band(12'h200, 12'h600, 6'd1, 100, 0, 0);
    checks++; if (beats_a.size() !== 32) $display("[TB] FAIL signed_beats got %0d want 32", beats_a.size()); else passes++;
    if (beats_a.size() >= 2) begin
      v = $signed(beats_a[0]);
      checks++; if (v != -128) $display("[TB] FAIL signed_a0 got %0d want -128", v); else passes++;
      v = $signed(beats_a[1]);
      checks++; if (v != 127) $display("[TB] FAIL signed_a1 got %0d want 127", v); else passes++;
      v = $signed(beats_b[0]);
      checks++; if (v != 127) $display("[TB] FAIL signed_b0 got %0d want 127", v); else passes++;
      v = $signed(beats_b[1]);
      checks++; if (v != -128) $display("[TB] FAIL signed_b1 got %0d want -128", v); else passes++;
    end
  endtask

  task automatic test_zero_rows();
    run_band(12'd5, 12'd9, 6'd0, 100, 0, 0);
    checks++; if (done_cyc !== 1) $display("[TB] FAIL zero_done_cyc got %0d want 1", done_cyc); else passes++;
    checks++; if (first_rd_cyc !== -1) $display("[TB] FAIL zero_rd_en got %0d want -1", first_rd_cyc); else passes++;
    checks++; if (beats_a.size() !== 0) $display("[TB] FAIL zero_beats got %0d want 0", beats_a.size()); else passes++;
    checks++; if ({done_pulses[1:0], busy_c1[0]} !== 3'b010) $display("[TB] FAIL zero_pulse_busy got %b want 010", {done_pulses[1:0], busy_c1[0]}); else passes++;
  endtask

  task automatic test_wrap();
    logic [11:0] want [8];
    want = '{12'hFFF, 12'h000, 12'h001, 12'h002, 12'h07F, 12'h080, 12'h081, 12'h082};
    run_band(12'hFFF, 12'h7FF, 6'd2, 100, 0, 0);
    checks++; if (addr1_q.size() !== 8) $display("[TB] FAIL wrap_reads got %0d want 8", addr1_q.size()); else passes++;
    for (int i = 0; i < 8 && i < addr1_q.size(); i++) begin
      checks++;
      if (addr1_q[i] !== want[i]) $display("[TB] FAIL wrap_addr[%0d] got %h want %h", i, addr1_q[i], want[i]);
      else passes++;
    end
    for (int n = 0; n < beats_a.size(); n++) begin
      checks++;
      if ({beats_a[n], beats_b[n]} !== {exp_a(12'hFFF, n), exp_b(12'h7FF, n)})
        $display("[TB] FAIL wrap_beat[%0d] got %h want %h", n, {beats_a[n], beats_b[n]}, {exp_a(12'hFFF, n), exp_b(12'h7FF, n)});
      else passes++;
    end
  endtask

  task automatic test_start_during_run();
    run_band(12'h100, 12'h900, 6'd2, 100, 4, 0);
    checks++; if (beats_a.size() !== 64) $display("[TB] FAIL restart_beats got %0d want 64", beats_a.size()); else passes++;
    checks++; if (done_pulses !== 1) $display("[TB] FAIL restart_done_pulses got %0d want 1", done_pulses); else passes++;
    for (int i = 0; i < addr1_q.size(); i++) begin
      checks++;
      if (addr1_q[i] !== 12'(12'h100 + (i / 4) * 128 + i % 4))
        $display("[TB] FAIL restart_addr[%0d] got %h want %h", i, addr1_q[i], 12'(12'h100 + (i / 4) * 128 + i % 4));
      else passes++;
    end
    for (int n = 0; n < beats_a.size(); n++) begin
      checks++;
      if ({beats_a[n], beats_b[n]} !== {exp_a(12'h100, n), exp_b(12'h900, n)})
        $display("[TB] FAIL restart_beat[%0d] got %h want %h", n, {beats_a[n], beats_b[n]}, {exp_a(12'h100, n), exp_b(12'h900, n)});
      else passes++;
    end
  endtask

  task automatic test_reset_mid_band();
    logic seen;
    run_band(12'h010, 12'h810, 6'd2, 100, 0, 10);
    checks++; if (beats_a.size() !== 10) $display("[TB] FAIL midrst_pre_beats got %0d want 10", beats_a.size()); else passes++;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({rd_en, addr1, addr2, pix_a, pix_b, pix_valid, row_last, frame_last, busy, done} !== '0)
      $display("[TB] FAIL midrst_async got %h want 0",
               {rd_en, addr1, addr2, pix_a, pix_b, pix_valid, row_last, frame_last, busy, done});
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pix_valid || rd_en || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("[TB] FAIL midrst_stale got %b want 0", seen); else passes++;
    run_band(12'h010, 12'h810, 6'd2, 100, 0, 0);
    checks++; if (beats_a.size() !== 64) $display("[TB] FAIL midrst_beats got %0d want 64", beats_a.size()); else passes++;
    checks++; if (first_valid_cyc !== 3) $display("[TB] FAIL midrst_first_valid got %0d want 3", first_valid_cyc); else passes++;
    checks++;
    if (addr1_q.size() == 0 || addr1_q[0] !== 12'h010) $display("[TB] FAIL midrst_first_addr got %h want 010", addr1_q.size() ? addr1_q[0] : 12'hxxx);
    else passes++;
    for (int n = 0; n < beats_a.size(); n++) begin
      checks++;
      if ({beats_a[n], beats_b[n], rl_q[n], fl_q[n]} !== {exp_a(12'h010, n), exp_b(12'h810, n), n % 32 == 31, n == 63})
        $display("[TB] FAIL midrst_beat[%0d] got %h want %h", n, {beats_a[n], beats_b[n], rl_q[n], fl_q[n]},
                 {exp_a(12'h010, n), exp_b(12'h810, n), n % 32 == 31, n == 63});
      else passes++;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pix_ready = 1'b0;
    base_addr_1 = '0; base_addr_2 = '0; num_rows = '0;
    for (int a = 0; a < 4096; a++) begin
      mem1[a] = pat(a, 1);
      mem2[a] = pat(a, 150);
    end
    test_reset();
    test_basic_read();
    test_row_stride();
    test_backpressure();
    test_signed();
    test_zero_rows();
    test_wrap();
    test_start_during_run();
    test_reset_mid_band();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
